// File: rtl/llc_update_pkg.sv
// Shared types and constants for the LLC update engine: entry layout, packet ops,
// FSM states and the cache state/hprot encodings.
package llc_update_pkg;

  localparam int unsigned STATE_W   = 2;
  localparam int unsigned TAG_W     = 40;
  localparam int unsigned SHARERS_W = 16;
  localparam int unsigned OWNER_W   = 4;
  localparam int unsigned LINE_W    = 192;

  // Cache line state and hprot encodings shared with the rest of the cache
  localparam logic [STATE_W-1:0] INVALID = 2'd0;
  localparam logic [STATE_W-1:0] VALID   = 2'd1;
  localparam logic               DATA    = 1'b1;

  typedef struct packed {
    logic [TAG_W-1:0]     tag;
    logic [STATE_W-1:0]   state;
    logic                 dirty;
    logic                 hprot;
    logic [SHARERS_W-1:0] sharers;
    logic [OWNER_W-1:0]   owner;
    logic [LINE_W-1:0]    line;
  } llc_entry_t;

  localparam int unsigned ENTRY_W = $bits(llc_entry_t);

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_FLUSH = 2'b01,
    OP_RST   = 2'b10,
    OP_RSVD  = 2'b11
  } update_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } update_state_t;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + 6'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/llc_update_engine_flush_mask.sv
// Combinational flush mask: selects ways holding valid data lines from a
// per-way state/hprot snapshot. Also usable by the evict logic.
module llc_flush_mask
  import llc_update_pkg::*;
#(
  parameter int unsigned WAYS = 16
) (
  input  logic [2*WAYS-1:0] states,
  input  logic [WAYS-1:0]   hprots,
  output logic [WAYS-1:0]   mask_c
);

  always_comb begin
    mask_c = '0;
    for (int w = 0; w < WAYS; w++) begin
      mask_c[w] = (states[2*w +: 2] == VALID) && (hprots[w] == DATA);
    end
  end

endmodule

// File: rtl/llc_update_engine.sv
// LLC update engine: turns WRITE/FLUSH/RST packets into registered array write
// commands, sweeps all sets on RST. Optional stats via LLC_UPDATE_STATS_EN.
module llc_update_engine
  import llc_update_pkg::*;
#(
  parameter int unsigned WAYS     = 16,
  parameter int unsigned SET_BITS = 9,
  parameter int unsigned ENTRY_W  = llc_update_pkg::ENTRY_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                in_op,
  input  logic [SET_BITS-1:0]       in_set,
  input  logic [$clog2(WAYS)-1:0]   in_way,
  input  logic [ENTRY_W-1:0]        in_entry,
  input  logic                      in_evict_we,
  input  logic [$clog2(WAYS)-1:0]   in_evict_way,
  input  logic [2*WAYS-1:0]         in_states,
  input  logic [WAYS-1:0]           in_hprots,
  input  logic                      in_last,
  output logic                      wr_valid,
  input  logic                      wr_ready,
  output logic [SET_BITS-1:0]       wr_set,
  output logic [WAYS-1:0]           wr_way_mask,
  output logic                      wr_inval,
  output logic [ENTRY_W-1:0]        wr_entry,
  output logic                      wr_evict_en,
  output logic [$clog2(WAYS)-1:0]   wr_evict_way,
  output logic                      done_valid,
  input  logic                      done_ready,
  output logic                      busy
`ifdef LLC_UPDATE_STATS_EN
  ,
  output logic [31:0]               stat_writes,
  output logic [31:0]               stat_inval_lines
`endif
);

  localparam int unsigned WAY_BITS = $clog2(WAYS);
  localparam logic [SET_BITS-1:0] LAST_SET = '1;

  update_state_t        state;
  logic [SET_BITS-1:0]  sweep_cnt;
  logic [WAYS-1:0]      flush_mask_c;
  logic                 load;
  logic                 wr_fire;
  logic                 accept;

  llc_flush_mask #(.WAYS(WAYS)) u_flush_mask (
    .states (in_states),
    .hprots (in_hprots),
    .mask_c (flush_mask_c)
  );

  // Output register can take a new command when empty or draining this cycle
  assign load     = !wr_valid || wr_ready;
  assign wr_fire  = wr_valid && wr_ready;
  assign in_ready = (state == IDLE) && load;
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE) || wr_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      sweep_cnt    <= '0;
      wr_valid     <= 1'b0;
      wr_set       <= '0;
      wr_way_mask  <= '0;
      wr_inval     <= 1'b0;
      wr_entry     <= '0;
      wr_evict_en  <= 1'b0;
      wr_evict_way <= '0;
      done_valid   <= 1'b0;
    end else begin
      if (wr_fire) wr_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            case (update_op_t'(in_op))
              OP_WRITE: begin
                wr_valid     <= 1'b1;
                wr_set       <= in_set;
                wr_way_mask  <= WAYS'(1) << in_way;
                wr_inval     <= 1'b0;
                wr_entry     <= in_entry;
                wr_evict_en  <= in_evict_we;
                wr_evict_way <= in_evict_way;
              end
              OP_FLUSH: begin
                if (|flush_mask_c) begin
                  wr_valid     <= 1'b1;
                  wr_set       <= in_set;
                  wr_way_mask  <= flush_mask_c;
                  wr_inval     <= 1'b1;
                  wr_evict_en  <= 1'b0;
                  wr_evict_way <= '0;
                end
                // With a write pending, DONE waits for its handshake before raising done_valid
                if (in_last) begin
                  state      <= DONE;
                  done_valid <= ~|flush_mask_c;
                end
              end
              OP_RST: begin
                wr_valid     <= 1'b1;
                wr_set       <= '0;
                wr_way_mask  <= '1;
                wr_inval     <= 1'b1;
                wr_evict_en  <= 1'b1;
                wr_evict_way <= '0;
                sweep_cnt    <= SET_BITS'(1);
                state        <= SWEEP;
              end
              default: ;
            endcase
          end
        end
        SWEEP: begin
          if (load) begin
            wr_valid     <= 1'b1;
            wr_set       <= sweep_cnt;
            wr_way_mask  <= '1;
            wr_inval     <= 1'b1;
            wr_evict_en  <= 1'b1;
            wr_evict_way <= '0;
            if (sweep_cnt == LAST_SET) begin
              sweep_cnt <= '0;
              state     <= DONE;
            end else begin
              sweep_cnt <= sweep_cnt + SET_BITS'(1);
            end
          end
        end
        DONE: begin
          if (done_valid) begin
            if (done_ready) begin
              done_valid <= 1'b0;
              state      <= IDLE;
            end
          end else if (load) begin
            done_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LLC_UPDATE_STATS_EN
  logic [32:0] inval_sum_c;

  always_comb begin
    inval_sum_c = 33'(stat_inval_lines) + 33'(popcount32(32'(wr_way_mask)));
  end

  // Saturating handshake and invalidated-line counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_writes      <= '0;
      stat_inval_lines <= '0;
    end else if (wr_fire) begin
      if (stat_writes != '1) stat_writes <= stat_writes + 32'd1;
      if (wr_inval) stat_inval_lines <= inval_sum_c[32] ? '1 : inval_sum_c[31:0];
    end
  end
`endif

  logic unused_ok;
  assign unused_ok = ^{WAY_BITS};

endmodule

// File: tb/tb_llc_update_engine.sv
// Scoreboard bench for llc_update_engine (WAYS=4, SET_BITS=2): expected write
// commands are queued at stimulus time and checked on each array handshake.
module tb_llc_update_engine;
  import llc_update_pkg::*;

  localparam int unsigned WAYS     = 4;
  localparam int unsigned SET_BITS = 2;
  localparam int unsigned WB       = 2;
  localparam int unsigned EW       = ENTRY_W;

  typedef struct {
    logic [SET_BITS-1:0] set;
    logic [WAYS-1:0]     mask;
    logic                inval;
    logic [EW-1:0]       entry;
    logic                evict_en;
    logic [WB-1:0]       evict_way;
  } exp_t;

  logic                clk, rst;
  logic                in_valid, in_ready;
  logic [1:0]          in_op;
  logic [SET_BITS-1:0] in_set;
  logic [WB-1:0]       in_way;
  logic [EW-1:0]       in_entry;
  logic                in_evict_we;
  logic [WB-1:0]       in_evict_way;
  logic [2*WAYS-1:0]   in_states;
  logic [WAYS-1:0]     in_hprots;
  logic                in_last;
  logic                wr_valid, wr_ready;
  logic [SET_BITS-1:0] wr_set;
  logic [WAYS-1:0]     wr_way_mask;
  logic                wr_inval;
  logic [EW-1:0]       wr_entry;
  logic                wr_evict_en;
  logic [WB-1:0]       wr_evict_way;
  logic                done_valid, done_ready, busy;
`ifdef LLC_UPDATE_STATS_EN
  logic [31:0]         stat_writes, stat_inval_lines;
`endif

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_hs     = 0;

  llc_update_engine #(.WAYS(WAYS), .SET_BITS(SET_BITS), .ENTRY_W(EW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_set(in_set),
    .in_way(in_way), .in_entry(in_entry), .in_evict_we(in_evict_we),
    .in_evict_way(in_evict_way), .in_states(in_states), .in_hprots(in_hprots),
    .in_last(in_last),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_set(wr_set),
    .wr_way_mask(wr_way_mask), .wr_inval(wr_inval), .wr_entry(wr_entry),
    .wr_evict_en(wr_evict_en), .wr_evict_way(wr_evict_way),
    .done_valid(done_valid), .done_ready(done_ready), .busy(busy)
`ifdef LLC_UPDATE_STATS_EN
    , .stat_writes(stat_writes), .stat_inval_lines(stat_inval_lines)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pop and compare on every array handshake, sampled just before the rising edge
  always begin : monitor
    exp_t e;
    @(negedge clk);
    #2;
    if (!rst && wr_valid && wr_ready) begin
      n_hs++;
      if (sb.size() == 0) begin
        check("unexpected_wr", 1, 0);
      end else begin
        e = sb.pop_front();
        check("wr_set", wr_set, e.set);
        check("wr_mask", wr_way_mask, e.mask);
        check("wr_inval", wr_inval, e.inval);
        check("wr_evict_en", wr_evict_en, e.evict_en);
        if (e.evict_en) check("wr_evict_way", wr_evict_way, e.evict_way);
        if (!e.inval) check("wr_entry", wr_entry, e.entry);
      end
    end
  end

  function automatic exp_t mk(input logic [SET_BITS-1:0] s, input logic [WAYS-1:0] m,
                              input logic inv, input logic [EW-1:0] en,
                              input logic ee, input logic [WB-1:0] ew);
    exp_t e;
    e.set = s; e.mask = m; e.inval = inv; e.entry = en; e.evict_en = ee; e.evict_way = ew;
    return e;
  endfunction

  task automatic set_pkt(input logic [1:0] op, input logic [SET_BITS-1:0] s, input logic [WB-1:0] w,
                         input logic [EW-1:0] en, input logic ewe, input logic [WB-1:0] ew,
                         input logic [2*WAYS-1:0] st, input logic [WAYS-1:0] hp, input logic last);
    in_op = op; in_set = s; in_way = w; in_entry = en; in_evict_we = ewe;
    in_evict_way = ew; in_states = st; in_hprots = hp; in_last = last;
  endtask

  // Holds the packet until accepted; returns the accepting edge number
  task automatic send(input logic [1:0] op, input logic [SET_BITS-1:0] s, input logic [WB-1:0] w,
                      input logic [EW-1:0] en, input logic ewe, input logic [WB-1:0] ew,
                      input logic [2*WAYS-1:0] st, input logic [WAYS-1:0] hp, input logic last,
                      output int acc);
    int t;
    set_pkt(op, s, w, en, ewe, ew, st, hp, last);
    in_valid = 1'b1;
    t = 0;
    #1;
    while (!in_ready && t < 50) begin
      @(negedge clk); #1; t++;
    end
    if (!in_ready) check("accept_timeout", 0, 1);
    acc = cyc + 1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_cyc);
    int t;
    t = 0;
    #1;
    while (!done_valid && t < 30) begin
      @(negedge clk); #1; t++;
    end
    check({tag, "_seen"}, done_valid, 1);
    check({tag, "_lat"}, cyc, exp_cyc);
  endtask

  task automatic ack_done(input int hold);
    repeat (hold) begin
      @(negedge clk); #1;
      check("done_hold", done_valid, 1);
      check("done_hold_rdy", in_ready, 0);
    end
    done_ready = 1'b1;
    @(negedge clk);
    done_ready = 1'b0;
    #1;
    check("done_clear", done_valid, 0);
    check("idle_rdy", in_ready, 1);
  endtask

  localparam logic [2*WAYS-1:0] ST_MIX   = {VALID, VALID, INVALID, VALID};
  localparam logic [2*WAYS-1:0] ST_INVAL = {INVALID, INVALID, INVALID, INVALID};

  initial begin
    int acc, hs0;
    logic [EW-1:0] e1, e2, e3, ea5;
    ea5 = {32{8'hA5}};
    e1  = {8{32'h1111_0001}};
    e2  = {8{32'h2222_0002}};
    e3  = {8{32'h3333_0003}};

    rst = 1'b1; in_valid = 1'b0; wr_ready = 1'b1; done_ready = 1'b0;
    set_pkt(2'b00, '0, '0, '0, 1'b0, '0, '0, '0, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_done", done_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_set", wr_set, 0);
    check("rst_wr_mask", wr_way_mask, 0);
    check("rst_wr_entry", wr_entry, 0);
    rst = 1'b0;
    #1 check("rst_in_ready", in_ready, 1);
    @(negedge clk);

    // Single WRITE, one-cycle latency
    sb.push_back(mk(2'd2, 4'b1000, 1'b0, ea5, 1'b1, 2'd1));
    send(2'b00, 2'd2, 2'd3, ea5, 1'b1, 2'd1, '0, '0, 1'b0, acc);
    #1;
    check("w1_latency", wr_valid, 1);
    check("w1_mask", wr_way_mask, 4'b1000);
    check("w1_busy", busy, 1);
    @(negedge clk);

    // Back-to-back WRITEs with three stalled cycles
    hs0 = n_hs;
    sb.push_back(mk(2'd1, 4'b0001, 1'b0, e1, 1'b0, 2'd0));
    sb.push_back(mk(2'd3, 4'b0100, 1'b0, e2, 1'b1, 2'd2));
    sb.push_back(mk(2'd0, 4'b0010, 1'b0, e3, 1'b0, 2'd0));
    wr_ready = 1'b0;
    set_pkt(2'b00, 2'd1, 2'd0, e1, 1'b0, 2'd0, '0, '0, 1'b0);
    in_valid = 1'b1;
    #1 check("bp_rdy_w1", in_ready, 1);
    @(negedge clk);
    set_pkt(2'b00, 2'd3, 2'd2, e2, 1'b1, 2'd2, '0, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready", in_ready, 0);
      check("bp_hold_valid", wr_valid, 1);
      check("bp_hold_set", wr_set, 2'd1);
      check("bp_hold_mask", wr_way_mask, 4'b0001);
      check("bp_hold_entry", wr_entry, e1);
      @(negedge clk);
    end
    wr_ready = 1'b1;
    #1 check("bp_rdy_w2", in_ready, 1);
    @(negedge clk);
    set_pkt(2'b00, 2'd0, 2'd1, e3, 1'b0, 2'd0, '0, '0, 1'b0);
    #1 check("bp_rdy_w3", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("bp_count", n_hs - hs0, 3);
    check("bp_sb_empty", sb.size(), 0);

    // Reserved op: accepted, nothing issued
    send(2'b11, 2'd1, 2'd0, '0, 1'b1, 2'd1, ST_MIX, 4'b1011, 1'b1, acc);
    #1;
    check("rsvd_no_wr", wr_valid, 0);
    check("rsvd_busy", busy, 0);
    check("rsvd_rdy", in_ready, 1);
    @(negedge clk);

    // FLUSH with data lines, last packet
    sb.push_back(mk(2'd1, 4'b1001, 1'b1, '0, 1'b0, 2'd0));
    send(2'b01, 2'd1, 2'd0, '0, 1'b0, 2'd0, ST_MIX, 4'b1011, 1'b1, acc);
    wait_done("flush", acc + 1);
    ack_done(0);
    check("flush_sb_empty", sb.size(), 0);
    @(negedge clk);

    // FLUSH with nothing to invalidate
    hs0 = n_hs;
    send(2'b01, 2'd3, 2'd0, '0, 1'b0, 2'd0, ST_INVAL, 4'b1111, 1'b1, acc);
    #1 check("eflush_no_wr", wr_valid, 0);
    wait_done("eflush", acc);
    ack_done(0);
    check("eflush_no_hs", n_hs - hs0, 0);
    @(negedge clk);

    // Full reset sweep
    hs0 = n_hs;
    for (int s = 0; s < 4; s++) sb.push_back(mk(SET_BITS'(s), 4'b1111, 1'b1, '0, 1'b1, 2'd0));
    send(2'b10, 2'd3, 2'd2, '0, 1'b0, 2'd3, '0, '0, 1'b0, acc);
    #1 check("sweep_rdy", in_ready, 0);
    wait_done("sweep", acc + 4);
    check("sweep_count", n_hs - hs0, 4);
    ack_done(2);
    @(negedge clk);

    // Asynchronous reset in mid-sweep, then a fresh sweep
    for (int s = 0; s < 4; s++) sb.push_back(mk(SET_BITS'(s), 4'b1111, 1'b1, '0, 1'b1, 2'd0));
    send(2'b10, 2'd0, 2'd0, '0, 1'b0, 2'd0, '0, '0, 1'b0, acc);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_wr_valid", wr_valid, 0);
    check("mid_rst_done", done_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_left", sb.size(), 2);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    hs0 = n_hs;
    for (int s = 0; s < 4; s++) sb.push_back(mk(SET_BITS'(s), 4'b1111, 1'b1, '0, 1'b1, 2'd0));
    send(2'b10, 2'd0, 2'd0, '0, 1'b0, 2'd0, '0, '0, 1'b0, acc);
    wait_done("resweep", acc + 4);
    check("resweep_count", n_hs - hs0, 4);
    ack_done(0);

    repeat (3) @(negedge clk);
    check("final_sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
